// File: rtl/gci_std_display_pkg.sv
// Shared definitions for the display controller register window: addresses,
// bit positions and request encoding.
package gci_std_display_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'h0;
    localparam logic [3:0] ADDR_RESOLUTION = 4'h1;
    localparam logic [3:0] ADDR_BGCOLOR    = 4'h2;
    localparam logic [3:0] ADDR_INT_ENA    = 4'h3;
    localparam logic [3:0] ADDR_STATUS     = 4'h4;
    localparam logic [3:0] ADDR_INT_STATUS = 4'h5;
    localparam logic [3:0] ADDR_SCRATCH    = 4'h6;

    localparam int unsigned CTRL_ENA_BIT        = 0;
    localparam int unsigned CTRL_MODE_LSB       = 1;
    localparam int unsigned STATUS_SEQ_BUSY_BIT = 0;
    localparam int unsigned STATUS_DISP_ENA_BIT = 1;
    localparam int unsigned INT_VSYNC_BIT       = 0;

    typedef enum logic {
        REG_READ  = 1'b0,
        REG_WRITE = 1'b1
    } reg_rw_e;

    function automatic logic [31:0] packResolution(input int unsigned hRes, input int unsigned vRes);
        logic [31:0] h32;
        logic [31:0] v32;
        h32 = hRes;
        v32 = vRes;
        return {v32[15:0], h32[15:0]};
    endfunction

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// Two-entry, 32-bit synchronous FIFO; read data is the registered head entry.
module gci_std_display_sync_fifo (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iWR_EN,
    input  logic [31:0] iWR_DATA,
    input  logic        iRD_EN,
    output logic [31:0] oRD_DATA,
    output logic        oFULL,
    output logic        oEMPTY,
    output logic [1:0]  oCOUNT
);

    logic [31:0] mem [2];
    logic        wrPtr;
    logic        rdPtr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign push = iWR_EN && (count != 2'd2);
    assign pop  = iRD_EN && (count != 2'd0);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= iWR_DATA;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign oRD_DATA = mem[rdPtr];
    assign oFULL    = (count == 2'd2);
    assign oEMPTY   = (count == 2'd0);
    assign oCOUNT   = count;

endmodule

// File: rtl/gci_std_display_register_file.sv
// Control-bus register window for the display controller; buffered read
// return with back-pressure, display configuration outputs and vsync IRQ.
module gci_std_display_register_file
    import gci_std_display_pkg::*;
#(
    parameter int unsigned P_H_RES = 640,
    parameter int unsigned P_V_RES = 480
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iREG_ENA,
    input  logic        iREG_RW,
    input  logic [3:0]  iREG_ADDR,
    input  logic [31:0] iREG_DATA,
    output logic        oREG_BUSY,
    output logic        oREG_VALID,
    input  logic        iREG_BUSY,
    output logic [31:0] oREG_DATA,
    input  logic        iVSYNC_EVENT,
    input  logic        iSEQ_BUSY,
    output logic        oDISP_ENA,
    output logic [1:0]  oDISP_MODE,
    output logic [23:0] oBG_COLOR,
    output logic        oIRQ
);

    logic [2:0]  ctrlReg;
    logic [23:0] bgColorReg;
    logic        intEnaReg;
    logic        intStatusReg;
    logic [31:0] scratchReg;
    logic        irqReg;

    logic        intEnaNext;
    logic        intStatusNext;
    logic [31:0] readData;
    logic        accept;
    logic        wrAccept;
    logic        rdAccept;
    logic        popReq;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [1:0]  fifoCount;

    // Busy comes from the registered FIFO count only, so a pop in the same
    // cycle never lets an extra request through.
    assign accept   = iREG_ENA && !fifoFull;
    assign wrAccept = accept && (reg_rw_e'(iREG_RW) == REG_WRITE);
    assign rdAccept = accept && (reg_rw_e'(iREG_RW) == REG_READ);
    assign popReq   = !fifoEmpty && !iREG_BUSY;

    always_comb begin
        intEnaNext    = intEnaReg;
        intStatusNext = intStatusReg;
        if (wrAccept && iREG_ADDR == ADDR_INT_ENA) begin
            intEnaNext = iREG_DATA[0];
        end
        if (wrAccept && iREG_ADDR == ADDR_INT_STATUS && iREG_DATA[INT_VSYNC_BIT]) begin
            intStatusNext = 1'b0;
        end
        // A vsync arriving with a clear wins so no event is lost.
        if (iVSYNC_EVENT) begin
            intStatusNext = 1'b1;
        end
    end

    always_comb begin
        readData = '0;
        case (iREG_ADDR)
            ADDR_CTRL:       readData[2:0]  = ctrlReg;
            ADDR_RESOLUTION: readData       = packResolution(P_H_RES, P_V_RES);
            ADDR_BGCOLOR:    readData[23:0] = bgColorReg;
            ADDR_INT_ENA:    readData[0]    = intEnaReg;
            ADDR_STATUS: begin
                readData[STATUS_SEQ_BUSY_BIT] = iSEQ_BUSY;
                readData[STATUS_DISP_ENA_BIT] = ctrlReg[CTRL_ENA_BIT];
            end
            ADDR_INT_STATUS: readData[INT_VSYNC_BIT] = intStatusReg;
            ADDR_SCRATCH:    readData       = scratchReg;
            default:         readData       = '0;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ctrlReg      <= '0;
            bgColorReg   <= '0;
            intEnaReg    <= 1'b0;
            intStatusReg <= 1'b0;
            scratchReg   <= '0;
            irqReg       <= 1'b0;
        end else begin
            if (wrAccept) begin
                case (iREG_ADDR)
                    ADDR_CTRL:    ctrlReg    <= iREG_DATA[2:0];
                    ADDR_BGCOLOR: bgColorReg <= iREG_DATA[23:0];
                    ADDR_SCRATCH: scratchReg <= iREG_DATA;
                    default:      ;
                endcase
            end
            intEnaReg    <= intEnaNext;
            intStatusReg <= intStatusNext;
            irqReg       <= intEnaNext & intStatusNext;
        end
    end

    gci_std_display_sync_fifo u_readFifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iWR_EN      (rdAccept),
        .iWR_DATA    (readData),
        .iRD_EN      (popReq),
        .oRD_DATA    (oREG_DATA),
        .oFULL       (fifoFull),
        .oEMPTY      (fifoEmpty),
        .oCOUNT      (fifoCount)
    );

    assert property (@(posedge iCLOCK) fifoFull == (fifoCount == 2'd2));
    assert property (@(posedge iCLOCK) fifoEmpty == (fifoCount == 2'd0));

    assign oREG_BUSY  = fifoFull;
    assign oREG_VALID = !fifoEmpty;
    assign oDISP_ENA  = ctrlReg[CTRL_ENA_BIT];
    assign oDISP_MODE = ctrlReg[CTRL_MODE_LSB +: 2];
    assign oBG_COLOR  = bgColorReg;
    assign oIRQ       = irqReg;

endmodule

// File: tb/tb_gci_std_display_register_file.sv
// Scoreboard bench for gci_std_display_register_file: expected read data is
// queued at request time and compared as the DUT returns it.
module tb_gci_std_display_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iREG_ENA = 1'b0;
    logic        iREG_RW = 1'b0;
    logic [3:0]  iREG_ADDR = '0;
    logic [31:0] iREG_DATA = '0;
    logic        oREG_BUSY;
    logic        oREG_VALID;
    logic        iREG_BUSY = 1'b0;
    logic [31:0] oREG_DATA;
    logic        iVSYNC_EVENT = 1'b0;
    logic        iSEQ_BUSY = 1'b0;
    logic        oDISP_ENA;
    logic [1:0]  oDISP_MODE;
    logic [23:0] oBG_COLOR;
    logic        oIRQ;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    gci_std_display_register_file #(
        .P_H_RES(640),
        .P_V_RES(480)
    ) dut (
        .iCLOCK       (clk),
        .iRESET_SYNC  (rst),
        .iREG_ENA     (iREG_ENA),
        .iREG_RW      (iREG_RW),
        .iREG_ADDR    (iREG_ADDR),
        .iREG_DATA    (iREG_DATA),
        .oREG_BUSY    (oREG_BUSY),
        .oREG_VALID   (oREG_VALID),
        .iREG_BUSY    (iREG_BUSY),
        .oREG_DATA    (oREG_DATA),
        .iVSYNC_EVENT (iVSYNC_EVENT),
        .iSEQ_BUSY    (iSEQ_BUSY),
        .oDISP_ENA    (oDISP_ENA),
        .oDISP_MODE   (oDISP_MODE),
        .oBG_COLOR    (oBG_COLOR),
        .oIRQ         (oIRQ)
    );

    // Read-return monitor: a transfer completes at the next edge when valid && !busy.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!rst && oREG_VALID && !iREG_BUSY) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected: got %h, required no transfer", oREG_DATA);
            end else begin
                exp = expQ.pop_front();
                if (oREG_DATA !== exp) begin
                    errors++;
                    $display("FAIL rdata: got %h, required %h", oREG_DATA, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (oREG_BUSY && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (oREG_BUSY) begin
            errors++;
            $display("FAIL busy_timeout: got busy=%b, required 0 within 50 cycles", oREG_BUSY);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wait_not_busy();
        iREG_ENA = 1'b1; iREG_RW = 1'b1; iREG_ADDR = a; iREG_DATA = d;
        tick();
        iREG_ENA = 1'b0; iREG_RW = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        wait_not_busy();
        iREG_ENA = 1'b1; iREG_RW = 1'b0; iREG_ADDR = a;
        expQ.push_back(exp);
        tick();
        iREG_ENA = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending reads, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({oREG_BUSY, oREG_VALID, oDISP_ENA, oDISP_MODE, oBG_COLOR, oIRQ} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b ena=%b mode=%b bg=%h irq=%b, required all 0",
                     oREG_BUSY, oREG_VALID, oDISP_ENA, oDISP_MODE, oBG_COLOR, oIRQ);
        end
        checks++;
        if (oREG_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h, required 00000000", oREG_DATA);
        end
        rst = 1'b0;
        tick();
        do_read(4'h0, 32'h0);
        do_read(4'h2, 32'h0);
        do_read(4'h6, 32'h0);
        do_read(4'h5, 32'h0);
        drain();
    endtask

    task automatic test_ctrl();
        do_write(4'h0, 32'h0000_0005);
        checks++;
        if (oDISP_ENA !== 1'b1 || oDISP_MODE !== 2'b10) begin
            errors++;
            $display("FAIL ctrl_outputs: got ena=%b mode=%b, required ena=1 mode=10", oDISP_ENA, oDISP_MODE);
        end
        do_read(4'h0, 32'h0000_0005);
        checks++;
        if (oREG_VALID !== 1'b1) begin
            errors++;
            $display("FAIL read_latency: got valid=%b, required 1", oREG_VALID);
        end
        drain();
        do_write(4'h0, 32'hFFFF_FFFA);
        checks++;
        if (oDISP_ENA !== 1'b0 || oDISP_MODE !== 2'b01) begin
            errors++;
            $display("FAIL ctrl_mask: got ena=%b mode=%b, required ena=0 mode=01", oDISP_ENA, oDISP_MODE);
        end
        do_read(4'h0, 32'h0000_0002);
        do_write(4'h2, 32'hFF12_3456);
        checks++;
        if (oBG_COLOR !== 24'h123456) begin
            errors++;
            $display("FAIL bgcolor_out: got %h, required 123456", oBG_COLOR);
        end
        do_read(4'h2, 32'h0012_3456);
        drain();
    endtask

    task automatic test_readonly();
        do_read(4'h1, 32'h01E0_0280);
        do_write(4'h1, 32'hFFFF_FFFF);
        do_read(4'h1, 32'h01E0_0280);
        do_write(4'h0, 32'h0000_0001);
        iSEQ_BUSY = 1'b1;
        do_read(4'h4, 32'h0000_0003);
        do_write(4'h4, 32'hFFFF_FFFF);
        iSEQ_BUSY = 1'b0;
        do_read(4'h4, 32'h0000_0002);
        do_read(4'h9, 32'h0);
        do_write(4'hF, 32'h1234_5678);
        do_read(4'hF, 32'h0);
        drain();
    endtask

    task automatic test_irq();
        do_write(4'h3, 32'h0000_0001);
        iVSYNC_EVENT = 1'b1;
        tick();
        iVSYNC_EVENT = 1'b0;
        checks++;
        if (oIRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b, required 1", oIRQ);
        end
        iVSYNC_EVENT = 1'b1;
        iREG_ENA = 1'b1; iREG_RW = 1'b1; iREG_ADDR = 4'h5; iREG_DATA = 32'h1;
        tick();
        iVSYNC_EVENT = 1'b0; iREG_ENA = 1'b0; iREG_RW = 1'b0;
        checks++;
        if (oIRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got %b, required 1", oIRQ);
        end
        do_read(4'h5, 32'h1);
        do_read(4'h5, 32'h1);
        do_write(4'h5, 32'h1);
        checks++;
        if (oIRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b, required 0", oIRQ);
        end
        do_read(4'h5, 32'h0);
        do_write(4'h3, 32'h0);
        iVSYNC_EVENT = 1'b1;
        tick();
        iVSYNC_EVENT = 1'b0;
        checks++;
        if (oIRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got %b, required 0", oIRQ);
        end
        do_read(4'h5, 32'h1);
        do_write(4'h5, 32'h1);
        drain();
    endtask

    task automatic test_back_to_back();
        do_write(4'h6, 32'hA5A5_5A5A);
        do_write(4'h2, 32'h0000_0002);
        do_write(4'h3, 32'h0000_0003);
        drain();
        iREG_BUSY = 1'b1;
        iREG_ENA = 1'b1; iREG_RW = 1'b0; iREG_ADDR = 4'h6;
        expQ.push_back(32'hA5A5_5A5A);
        tick();
        checks++;
        if (oREG_VALID !== 1'b1 || oREG_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got valid=%b busy=%b, required valid=1 busy=0", oREG_VALID, oREG_BUSY);
        end
        iREG_ADDR = 4'h2;
        expQ.push_back(32'h0000_0002);
        tick();
        checks++;
        if (oREG_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got busy=%b, required 1", oREG_BUSY);
        end
        iREG_ADDR = 4'h3;
        expQ.push_back(32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (oREG_BUSY !== 1'b1 || oREG_VALID !== 1'b1 || oREG_DATA !== 32'hA5A5_5A5A) begin
                errors++;
                $display("FAIL bp_hold: got busy=%b valid=%b data=%h, required busy=1 valid=1 data=a5a55a5a",
                         oREG_BUSY, oREG_VALID, oREG_DATA);
            end
        end
        iREG_BUSY = 1'b0;
        tick();
        checks++;
        if (oREG_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got busy=%b, required 0", oREG_BUSY);
        end
        tick();
        iREG_ENA = 1'b0;
        drain();
        do_write(4'h6, 32'hDEAD_BEEF);
        do_read(4'h6, 32'hDEAD_BEEF);
        do_read(4'h9, 32'h0);
        drain();
    endtask

    task automatic test_mid_reset();
        do_write(4'h0, 32'h7);
        do_write(4'h2, 32'hFFFF_FFFF);
        do_write(4'h3, 32'h1);
        iVSYNC_EVENT = 1'b1;
        tick();
        iVSYNC_EVENT = 1'b0;
        iREG_BUSY = 1'b1;
        do_read(4'h6, 32'hDEAD_BEEF);
        do_read(4'h0, 32'h7);
        checks++;
        if (oREG_BUSY !== 1'b1 || oIRQ !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: got busy=%b irq=%b, required 1 1", oREG_BUSY, oIRQ);
        end
        rst = 1'b1;
        tick();
        expQ.delete();
        checks++;
        if ({oREG_BUSY, oREG_VALID, oDISP_ENA, oDISP_MODE, oBG_COLOR, oIRQ} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b valid=%b ena=%b mode=%b bg=%h irq=%b, required all 0",
                     oREG_BUSY, oREG_VALID, oDISP_ENA, oDISP_MODE, oBG_COLOR, oIRQ);
        end
        rst = 1'b0;
        iREG_BUSY = 1'b0;
        tick();
        checks++;
        if (oREG_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_discard: got valid=%b, required 0", oREG_VALID);
        end
        do_read(4'h6, 32'h0);
        do_read(4'h3, 32'h0);
        do_read(4'h5, 32'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_readonly();
        test_irq();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
